// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the IF/ID/EX hazard controller: FSM encoding,
// control-output bundle and its default (free-running) value.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_MULTI      = 2'b10
  } state_e;

  localparam logic [4:0]  ZERO_REG  = 5'd0;
  localparam int          CNT_W     = 4;
  localparam int          STALL_W   = 16;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic if_id_flush;
    logic ex_hold;
    logic multi_done;
  } ctrl_t;

  // Pipeline advancing normally: PC and IF/ID enabled, nothing inserted or held.
  localparam ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Combinational load-use compare between the load in ID/EX and the sources of
// the instruction in IF/ID. Register 0 is hardwired and never creates a hazard.
module load_use_detector
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ifIdRs,
  input  logic [REG_ADDR_W-1:0] ifIdRt,
  input  logic                  ifIdUsesRt,
  input  logic                  idExMemRead,
  input  logic [REG_ADDR_W-1:0] idExRt,
  output logic                  hit
);

  logic w_rs_match;
  logic w_rt_match;
  logic w_dest_nonzero;

  assign w_dest_nonzero = (idExRt != REG_ADDR_W'(ZERO_REG));
  assign w_rs_match     = (idExRt == ifIdRs);
  assign w_rt_match     = ifIdUsesRt && (idExRt == ifIdRt);
  assign hit            = idExMemRead && w_dest_nonzero && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the IF/ID/EX pipeline: load-use stall, branch flush and
// multi-cycle EX hold. Outputs decode state+inputs; stallCount is registered.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MULTI_LATENCY = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ifIdRs,
  input  logic [REG_ADDR_W-1:0] ifIdRt,
  input  logic                  ifIdUsesRt,
  input  logic                  idExMemRead,
  input  logic [REG_ADDR_W-1:0] idExRt,
  input  logic                  idExMulti,
  input  logic                  branchTaken,
  output logic                  pcWrite,
  output logic                  ifIdWrite,
  output logic                  idExBubble,
  output logic                  ifIdFlush,
  output logic                  exHold,
  output logic                  multiDone,
  output logic [STALL_W-1:0]    stallCount,
  output logic [1:0]            dbg_state
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [STALL_W-1:0] r_stall_count;

  state_e           w_next_state;
  logic [CNT_W-1:0] w_next_count;
  ctrl_t            w_ctrl;
  logic             w_hit;

  load_use_detector #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detector (
    .ifIdRs      (ifIdRs),
    .ifIdRt      (ifIdRt),
    .ifIdUsesRt  (ifIdUsesRt),
    .idExMemRead (idExMemRead),
    .idExRt      (idExRt),
    .hit         (w_hit)
  );

  always_comb begin
    w_ctrl       = CTRL_DEFAULT;
    w_next_state = r_state;
    w_next_count = r_count;
    if (!reset) begin
      case (r_state)
        ST_RUN: begin
          // A taken branch kills the younger instructions, so their hazards are moot.
          if (branchTaken) begin
            w_ctrl.if_id_flush  = 1'b1;
            w_ctrl.id_ex_bubble = 1'b1;
          end else if (idExMulti) begin
            w_ctrl.pc_write    = 1'b0;
            w_ctrl.if_id_write = 1'b0;
            w_ctrl.ex_hold     = 1'b1;
            w_next_state       = ST_MULTI;
            w_next_count       = CNT_W'(MULTI_LATENCY - 2);
          end else if (w_hit) begin
            w_ctrl.pc_write     = 1'b0;
            w_ctrl.if_id_write  = 1'b0;
            w_ctrl.id_ex_bubble = 1'b1;
            w_next_state        = ST_LOAD_STALL;
          end
        end
        ST_LOAD_STALL: begin
          w_next_state = ST_RUN;
        end
        ST_MULTI: begin
          if (r_count != '0) begin
            w_ctrl.pc_write    = 1'b0;
            w_ctrl.if_id_write = 1'b0;
            w_ctrl.ex_hold     = 1'b1;
            w_next_count       = r_count - 1'b1;
          end else begin
            w_ctrl.multi_done = 1'b1;
            w_next_state      = ST_RUN;
          end
        end
        default: begin
          w_next_state = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_count       <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      if (!w_ctrl.pc_write && (r_stall_count != STALL_MAX)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign pcWrite    = w_ctrl.pc_write;
  assign ifIdWrite  = w_ctrl.if_id_write;
  assign idExBubble = w_ctrl.id_ex_bubble;
  assign ifIdFlush  = w_ctrl.if_id_flush;
  assign exHold     = w_ctrl.ex_hold;
  assign multiDone  = w_ctrl.multi_done;
  assign stallCount = r_stall_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed hazard scenarios plus random
// traffic against an age/shadow model, and a long-running saturation instance.
module tb_pipeline_hazard_controller;

  localparam int L     = 4;
  localparam int L_SAT = 15;
  localparam int W     = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [W-1:0] ifIdRs, ifIdRt, idExRt;
  logic         ifIdUsesRt, idExMemRead, idExMulti, branchTaken;
  logic         pcWrite, ifIdWrite, idExBubble, ifIdFlush, exHold, multiDone;
  logic [15:0]  stallCount;
  logic [1:0]   dbg_state;

  logic         sat_reset;
  logic         s_pc, s_ifid, s_bub, s_flush, s_hold, s_done;
  logic [15:0]  s_stall;
  logic [1:0]   s_state;
  int           sat_cycles = 0;

  int checks = 0;
  int errors = 0;

  // Reference model: age of the multi-cycle op in EX (0 = none) and whether
  // the previous cycle inserted a load-use bubble.
  int m_age    = 0;
  bit m_shadow = 1'b0;
  int m_stall  = 0;

  pipeline_hazard_controller #(.MULTI_LATENCY(L), .REG_ADDR_W(W)) dut (
    .clk(clk), .reset(reset), .ifIdRs(ifIdRs), .ifIdRt(ifIdRt),
    .ifIdUsesRt(ifIdUsesRt), .idExMemRead(idExMemRead), .idExRt(idExRt),
    .idExMulti(idExMulti), .branchTaken(branchTaken), .pcWrite(pcWrite),
    .ifIdWrite(ifIdWrite), .idExBubble(idExBubble), .ifIdFlush(ifIdFlush),
    .exHold(exHold), .multiDone(multiDone), .stallCount(stallCount),
    .dbg_state(dbg_state)
  );

  // Back-to-back multi-cycle ops forever, used to drive stallCount into saturation.
  pipeline_hazard_controller #(.MULTI_LATENCY(L_SAT), .REG_ADDR_W(W)) dut_sat (
    .clk(clk), .reset(sat_reset), .ifIdRs(5'd0), .ifIdRt(5'd0),
    .ifIdUsesRt(1'b0), .idExMemRead(1'b0), .idExRt(5'd0),
    .idExMulti(1'b1), .branchTaken(1'b0), .pcWrite(s_pc),
    .ifIdWrite(s_ifid), .idExBubble(s_bub), .ifIdFlush(s_flush),
    .exHold(s_hold), .multiDone(s_done), .stallCount(s_stall),
    .dbg_state(s_state)
  );

  always @(posedge clk) if (!sat_reset) sat_cycles <= sat_cycles + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic br, input logic mem,
                       input logic multi, input logic uses,
                       input logic [W-1:0] rs, input logic [W-1:0] rt,
                       input logic [W-1:0] exrt);
    logic hit, e_pc, e_ifid, e_bub, e_fl, e_hold, e_done;
    @(negedge clk);
    reset = rst; branchTaken = br; idExMemRead = mem; idExMulti = multi;
    ifIdUsesRt = uses; ifIdRs = rs; ifIdRt = rt; idExRt = exrt;
    #1;
    hit = mem && (exrt != 0) && ((exrt == rs) || (uses && exrt == rt));
    e_pc = 1; e_ifid = 1; e_bub = 0; e_fl = 0; e_hold = 0; e_done = 0;
    if (rst) begin
    end else if (m_age > 0) begin
      if (m_age == L - 1) e_done = 1;
      else begin e_pc = 0; e_ifid = 0; e_hold = 1; end
    end else if (m_shadow) begin
    end else if (br) begin
      e_fl = 1; e_bub = 1;
    end else if (multi) begin
      e_pc = 0; e_ifid = 0; e_hold = 1;
    end else if (hit) begin
      e_pc = 0; e_ifid = 0; e_bub = 1;
    end
    chk("pcWrite",    {15'd0, pcWrite},    {15'd0, e_pc});
    chk("ifIdWrite",  {15'd0, ifIdWrite},  {15'd0, e_ifid});
    chk("idExBubble", {15'd0, idExBubble}, {15'd0, e_bub});
    chk("ifIdFlush",  {15'd0, ifIdFlush},  {15'd0, e_fl});
    chk("exHold",     {15'd0, exHold},     {15'd0, e_hold});
    chk("multiDone",  {15'd0, multiDone},  {15'd0, e_done});
    if (rst) begin
      m_age = 0; m_shadow = 0; m_stall = 0;
    end else begin
      if (!e_pc && m_stall < 65535) m_stall++;
      if (m_age > 0) m_age = (m_age == L - 1) ? 0 : m_age + 1;
      else if (m_shadow) m_shadow = 0;
      else if (br) begin end
      else if (multi) m_age = 1;
      else if (hit) m_shadow = 1;
    end
    @(posedge clk);
    #1;
    chk("stallCount", stallCount, 16'(m_stall));
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  function automatic logic [15:0] sat_exp(input int n);
    int s;
    s = n - (n + 1) / L_SAT;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  task automatic chk_sat(input string tag);
    int   k;
    logic rel;
    k   = sat_cycles;
    rel = ((k % L_SAT) == L_SAT - 1);
    chk(tag, s_stall, sat_exp(k));
    chk("sat_ctrl", {8'd0, s_pc, s_ifid, s_bub, s_flush, s_hold, s_done, s_state},
        {8'd0, rel, rel, 1'b0, 1'b0, !rel, rel, ((k % L_SAT) == 0) ? 2'b00 : 2'b10});
  endtask

  initial begin
    int guard;
    reset = 1; sat_reset = 1; branchTaken = 0; idExMemRead = 0; idExMulti = 0;
    ifIdUsesRt = 0; ifIdRs = 0; ifIdRt = 0; idExRt = 0;

    do_reset();
    do_reset();
    chk("reset_state", {14'd0, dbg_state}, 16'd0);
    @(negedge clk);
    sat_reset = 0;

    // Load-use on rs: exactly one stall cycle.
    cycle(0, 0, 1, 0, 0, 5'd5, 5'd0, 5'd5);
    idle();
    chk("loaduse_total", stallCount, 16'd1);

    // r0 and an unused rt never stall.
    cycle(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    cycle(0, 0, 1, 0, 0, 5'd3, 5'd7, 5'd7);
    chk("no_stall_total", stallCount, 16'd1);
    cycle(0, 0, 1, 0, 1, 5'd3, 5'd7, 5'd7);
    idle();

    // Multi-cycle op: three held cycles then the release pulse.
    do_reset();
    repeat (L) cycle(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    chk("multi_total", stallCount, 16'd3);
    idle();

    // Branch outranks a simultaneous load-use hit.
    cycle(0, 1, 1, 0, 0, 5'd9, 5'd0, 5'd9);
    idle();

    // Reset at the second MULTI cycle aborts without a release pulse.
    cycle(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    cycle(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    do_reset();
    chk("abort_total", stallCount, 16'd0);
    idle();
    idle();

    repeat (3000) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // Saturation: sample once just below the ceiling and once well past it.
    guard = 0;
    while (sat_cycles < 70000 && guard < 100000) begin @(negedge clk); guard++; end
    chk_sat("sat_below");
    while (sat_cycles < 70300 && guard < 100000) begin @(negedge clk); guard++; end
    chk_sat("sat_hold");
    repeat (20) @(negedge clk);
    chk_sat("sat_hold_late");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the IF/ID/EX pipeline around the execute stage. Generates PC and pipeline-register write enables, bubbles and flushes.
- Covers three hazards: load-use (1-cycle stall), taken branch resolved in EX (flush), and multi-cycle ALU operations (hold EX for a fixed latency).
- Sits beside the pipeline registers. Its state updates on posedge clk, so its outputs are stable before the pipeline registers latch on negedge clk.

Parameters:
- MULTI_LATENCY, 4, number of cycles a multi-cycle ALU op occupies EX; legal range 2..15.
- REG_ADDR_W, 5, register-address width.

Ports:
- clk  in  1  system clock; state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ifIdRs  in  REG_ADDR_W  rs field of the instruction in IF/ID.
- ifIdRt  in  REG_ADDR_W  rt field of the instruction in IF/ID.
- ifIdUsesRt  in  1  the IF/ID instruction reads rt as a source.
- idExMemRead  in  1  the ID/EX instruction is a load.
- idExRt  in  REG_ADDR_W  load destination register in ID/EX.
- idExMulti  in  1  the ID/EX instruction is a multi-cycle ALU op.
- branchTaken  in  1  branch resolved taken in EX this cycle.
- pcWrite  out  1  PC update enable.
- ifIdWrite  out  1  IF/ID register update enable.
- idExBubble  out  1  load zero control into ID/EX (insert nop).
- ifIdFlush  out  1  clear IF/ID to nop.
- exHold  out  1  EX/MEM register and execute operands hold their value.
- multiDone  out  1  one-cycle pulse when the multi-cycle op releases.
- stallCount  out  16  saturating count of cycles with pcWrite=0.

Behaviour:
- States: RUN, LOAD_STALL, MULTI. Internal count is 4 bits.
- Outputs are combinational from state and inputs. stallCount is registered.
- Defaults: pcWrite=1, ifIdWrite=1, idExBubble=0, ifIdFlush=0, exHold=0, multiDone=0.
- Reset (synchronous, active-high):
  - While reset=1, all outputs are at their defaults and stallCount=0.
  - On the edge with reset=1: state<=RUN, count<=0, stallCount<=0.
  - Reset mid-MULTI or mid-LOAD_STALL aborts immediately, with no multiDone pulse.
- Load-use hit (hit) = idExMemRead && idExRt!=0 && (idExRt==ifIdRs || (ifIdUsesRt && idExRt==ifIdRt)).
- RUN, priority order:
  1. branchTaken: ifIdFlush=1, idExBubble=1, pcWrite=1, ifIdWrite=1. Next state RUN. This suppresses hit and idExMulti.
  2. idExMulti: pcWrite=0, ifIdWrite=0, exHold=1. Next state MULTI, count<=MULTI_LATENCY-2.
  3. hit: pcWrite=0, ifIdWrite=0, idExBubble=1. Next state LOAD_STALL.
  4. Otherwise: defaults, stay in RUN.
- LOAD_STALL:
  - Lasts exactly one cycle. Hit detection is masked. Defaults apply. Next state RUN.
- MULTI:
  - branchTaken, hit and idExMulti are ignored.
  - count!=0: pcWrite=0, ifIdWrite=0, exHold=1, count<=count-1.
  - count==0: defaults plus multiDone=1. Next state RUN.
  - Total stalled cycles per multi-cycle op = MULTI_LATENCY-1.
  - Back-to-back multi-cycle ops: a new idExMulti is evaluated in the RUN cycle after release.
- stallCount:
  - Increments on posedge when pcWrite=0 and reset=0.
  - Saturates at 16'hFFFF; no wrap.
- Register 0 never causes a load-use stall.

Decomposition:
- Shared package:
  - State encodings RUN=2'b00, LOAD_STALL=2'b01, MULTI=2'b10.
  - ZERO_REG=5'd0.
  - Default-enable constants.
- Sub-module load_use_detector: purely combinational hit compare, inputs ifIdRs, ifIdRt, ifIdUsesRt, idExMemRead, idExRt.
- The FSM, counter and stallCount stay in the top module.

Test Plan:
- Load-use: idExMemRead=1, idExRt=5, ifIdRs=5 -> exactly one cycle of pcWrite=0, ifIdWrite=0, idExBubble=1, then defaults; stallCount=1.
- Zero register: idExMemRead=1, idExRt=0, ifIdRs=0 -> no stall, stallCount=0. Separately, ifIdRt=7 matches with ifIdUsesRt=0 -> no stall.
- Multi-cycle op: idExMulti=1 with MULTI_LATENCY=4 -> exHold=1 and pcWrite=0 for 3 cycles; multiDone pulses in cycle 4; stallCount=3.
- Branch priority: branchTaken=1 together with a load-use hit -> ifIdFlush=1, idExBubble=1, pcWrite=1, no LOAD_STALL; next cycle is defaults.
- Reset mid-MULTI: reset=1 at the second MULTI cycle -> the next cycle is RUN with defaults, no multiDone, stallCount=0.
- Saturation: force 65540 stall cycles -> stallCount holds at 16'hFFFF.
